// File: rtl/bacs_pkg.sv
// Shared types, constants and helper functions for the butterfly ACS engine.
package bacs_pkg;

    localparam int K_DEF   = 3;
    localparam int W_DEF   = 8;
    localparam int BMW_DEF = 2;
    localparam int S_DEF   = 1 << (K_DEF - 1);

    localparam logic [K_DEF-1:0] G0_DEF = 3'b111;
    localparam logic [K_DEF-1:0] G1_DEF = 3'b101;

    // Unreachable-path marker for the default metric width.
    localparam int unsigned PM_INF = (32'd1 << W_DEF) - 32'd1;

    typedef logic [K_DEF-2:0] state_idx_t;
    typedef logic [1:0]       label_t;
    typedef logic [((S_DEF / 2 > 1) ? $clog2(S_DEF / 2) : 1)-1:0] bfly_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Saturation value (sticky infinity) for a metric of width w.
    function automatic int unsigned pm_inf(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Encoder output label {c0,c1} for register contents r = {u, old_state}.
    function automatic label_t enc_label(input int unsigned r,
                                         input int unsigned g0,
                                         input int unsigned g1);
        return {^(r & g0), ^(r & g1)};
    endfunction

    // Normalise-add with sticky infinity; 32-bit intermediate cannot overflow.
    function automatic int unsigned sat_add(input int unsigned pm,
                                            input int unsigned norm,
                                            input int unsigned bm,
                                            input int unsigned inf);
        int unsigned s;
        if (pm == inf) begin
            return inf;
        end
        s = pm - norm + bm;
        return (s > inf) ? inf : s;
    endfunction

    // Old state feeding butterfly j on path b (0 = a, 1 = b).
    function automatic int unsigned pred_idx(input int unsigned j,
                                             input int unsigned b);
        return 2 * j + b;
    endfunction

    // New state produced by butterfly j for input bit u in an S-state trellis.
    function automatic int unsigned succ_idx(input int unsigned j,
                                             input int unsigned u,
                                             input int unsigned s);
        return j + u * (s / 2);
    endfunction

endpackage

// File: rtl/bacs_if.sv
// Branch-metric input handshake and decision/metric output bundle.
interface bacs_if
    import bacs_pkg::*;
#(
    parameter int K   = K_DEF,
    parameter int W   = W_DEF,
    parameter int BMW = BMW_DEF
) ();
    logic                      bm_valid;
    logic                      bm_ready;
    logic [4*BMW-1:0]          bm;
    logic                      dec_valid;
    logic [(1 << (K-1))-1:0]   dec;
    logic [K-2:0]              best_state;
    logic [W-1:0]              best_metric;
    logic                      busy;

    modport master (
        output bm_valid, bm,
        input  bm_ready, dec_valid, dec, best_state, best_metric, busy
    );

    modport slave (
        input  bm_valid, bm,
        output bm_ready, dec_valid, dec, best_state, best_metric, busy
    );
endinterface

// File: rtl/bacs_cell.sv
// Combinational normalise-add-saturate-compare-select for one new state.
module bacs_cell
    import bacs_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int BMW = BMW_DEF
) (
    input  logic [W-1:0]   i_pm_a,
    input  logic [W-1:0]   i_pm_b,
    input  logic [W-1:0]   i_norm,
    input  logic [BMW-1:0] i_bm_a,
    input  logic [BMW-1:0] i_bm_b,
    output logic [W-1:0]   o_pm,
    output logic           o_dec
);
    localparam int unsigned INF = pm_inf(W);

    logic [W-1:0] w_sum_a;
    logic [W-1:0] w_sum_b;

    assign w_sum_a = W'(sat_add(32'(i_pm_a), 32'(i_norm), 32'(i_bm_a), INF));
    assign w_sum_b = W'(sat_add(32'(i_pm_b), 32'(i_norm), 32'(i_bm_b), INF));

    // Ties resolve to path a (decision 0).
    assign o_dec = (w_sum_b < w_sum_a);
    assign o_pm  = o_dec ? w_sum_b : w_sum_a;
endmodule

// File: rtl/bacs_engine.sv
// Time-multiplexed ACS engine: one butterfly per cycle over all trellis states.
module bacs_engine
    import bacs_pkg::*;
#(
    parameter int             K   = K_DEF,
    parameter int             W   = W_DEF,
    parameter int             BMW = BMW_DEF,
    parameter logic [K-1:0]   G0  = G0_DEF,
    parameter logic [K-1:0]   G1  = G1_DEF
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  i_init,
    bacs_if.slave bus
);
    localparam int S  = 1 << (K - 1);
    localparam int H  = S / 2;
    localparam int SW = K - 1;
    localparam int JW = (H > 1) ? $clog2(H) : 1;
    localparam logic [W-1:0] PM_MAX = W'(pm_inf(W));

    fsm_t             r_state, w_next;
    logic [JW-1:0]    r_j;
    logic [4*BMW-1:0] r_bm;
    logic [W-1:0]     r_pm [2][S];
    logic             r_bank;
    logic [W-1:0]     r_norm;
    logic [S-1:0]     r_dec_acc, r_dec;
    logic [W-1:0]     r_min, r_best_metric;
    logic [SW-1:0]    r_min_idx, r_best_state;

    logic             w_accept, w_last;
    logic [SW-1:0]    w_old_a, w_old_b, w_new0, w_new1;
    label_t           w_lab_a0, w_lab_b0, w_lab_a1, w_lab_b1;
    logic [W-1:0]     w_pm0, w_pm1;
    logic             w_d0, w_d1;
    logic [S-1:0]     w_dec_nxt;
    logic [W-1:0]     w_min;
    logic [SW-1:0]    w_min_idx;

    assign w_accept = (r_state == ST_IDLE) && bus.bm_valid && !i_init;
    assign w_last   = (r_j == JW'(H - 1));

    assign w_old_a  = SW'(pred_idx(32'(r_j), 0));
    assign w_old_b  = SW'(pred_idx(32'(r_j), 1));
    assign w_new0   = SW'(succ_idx(32'(r_j), 0, S));
    assign w_new1   = SW'(succ_idx(32'(r_j), 1, S));

    assign w_lab_a0 = enc_label(32'(w_old_a), 32'(G0), 32'(G1));
    assign w_lab_b0 = enc_label(32'(w_old_b), 32'(G0), 32'(G1));
    assign w_lab_a1 = enc_label(32'(w_old_a) | (32'd1 << (K - 1)), 32'(G0), 32'(G1));
    assign w_lab_b1 = enc_label(32'(w_old_b) | (32'd1 << (K - 1)), 32'(G0), 32'(G1));

    bacs_cell #(.W(W), .BMW(BMW)) u_cell_lo (
        .i_pm_a (r_pm[r_bank][w_old_a]),
        .i_pm_b (r_pm[r_bank][w_old_b]),
        .i_norm (r_norm),
        .i_bm_a (r_bm[BMW*w_lab_a0 +: BMW]),
        .i_bm_b (r_bm[BMW*w_lab_b0 +: BMW]),
        .o_pm   (w_pm0),
        .o_dec  (w_d0)
    );

    bacs_cell #(.W(W), .BMW(BMW)) u_cell_hi (
        .i_pm_a (r_pm[r_bank][w_old_a]),
        .i_pm_b (r_pm[r_bank][w_old_b]),
        .i_norm (r_norm),
        .i_bm_a (r_bm[BMW*w_lab_a1 +: BMW]),
        .i_bm_b (r_bm[BMW*w_lab_b1 +: BMW]),
        .o_pm   (w_pm1),
        .o_dec  (w_d1)
    );

    assign bus.bm_ready    = (r_state == ST_IDLE);
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.dec_valid   = (r_state == ST_DONE) && !i_init;
    assign bus.dec         = r_dec;
    assign bus.best_state  = r_best_state;
    assign bus.best_metric = r_best_metric;

    // Running minimum over this step's outputs; equal metrics keep the lower state index.
    always_comb begin
        w_min     = (r_j == '0) ? PM_MAX : r_min;
        w_min_idx = (r_j == '0) ? {SW{1'b1}} : r_min_idx;
        if ((w_pm0 < w_min) || ((w_pm0 == w_min) && (w_new0 < w_min_idx))) begin
            w_min     = w_pm0;
            w_min_idx = w_new0;
        end
        if ((w_pm1 < w_min) || ((w_pm1 == w_min) && (w_new1 < w_min_idx))) begin
            w_min     = w_pm1;
            w_min_idx = w_new1;
        end
    end

    // Decision word accumulation, restarted on the first butterfly of a step.
    always_comb begin
        w_dec_nxt         = (r_j == '0) ? '0 : r_dec_acc;
        w_dec_nxt[w_new0] = w_d0;
        w_dec_nxt[w_new1] = w_d1;
    end

    // Step sequencing: accept, sweep butterflies, publish; init forces IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.bm_valid) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (i_init) begin
            w_next = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Metric banks, butterfly counter, normaliser and published results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < S; i++) begin
                    r_pm[b][i] <= (i == 0) ? '0 : PM_MAX;
                end
            end
            r_bank        <= 1'b0;
            r_norm        <= '0;
            r_j           <= '0;
            r_bm          <= '0;
            r_dec_acc     <= '0;
            r_min         <= '0;
            r_min_idx     <= '0;
            r_dec         <= '0;
            r_best_state  <= '0;
            r_best_metric <= '0;
        end else if (i_init) begin
            for (int i = 0; i < S; i++) begin
                r_pm[0][i] <= (i == 0) ? '0 : PM_MAX;
            end
            r_bank        <= 1'b0;
            r_norm        <= '0;
            r_j           <= '0;
            r_dec         <= '0;
            r_best_state  <= '0;
            r_best_metric <= '0;
        end else begin
            if (w_accept) begin
                r_bm <= bus.bm;
                r_j  <= '0;
            end
            if (r_state == ST_RUN) begin
                r_pm[~r_bank][w_new0] <= w_pm0;
                r_pm[~r_bank][w_new1] <= w_pm1;
                r_dec_acc             <= w_dec_nxt;
                r_min                 <= w_min;
                r_min_idx             <= w_min_idx;
                r_j                   <= r_j + JW'(1);
                if (w_last) begin
                    r_dec         <= w_dec_nxt;
                    r_best_state  <= w_min_idx;
                    r_best_metric <= w_min;
                end
            end
            if (r_state == ST_DONE) begin
                r_bank <= ~r_bank;
                r_norm <= r_best_metric;
            end
        end
    end
endmodule
